// File: rtl/link_sched_pkg.sv
// Shared link word definitions: control words, header layout and scheduler state encoding.
// The link receiver imports this package too, so both ends agree on the wire format.
package link_sched_pkg;

  localparam logic [15:0] IDLE_WORD  = 16'h50BC;
  localparam logic [15:0] TRIG_WORD  = 16'h001C;
  localparam logic [15:0] ABORT_WORD = 16'h00FE;

  localparam int HDR_FLAG_BIT = 15;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_W    = 12;

  typedef logic [HDR_LEN_W-1:0] hdr_len_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_GAP  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  function automatic hdr_len_t hdr_len(input logic [15:0] w);
    return w[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

  function automatic logic [15:0] make_hdr(input hdr_len_t len);
    logic [15:0] w;
    w = '0;
    w[HDR_FLAG_BIT] = 1'b1;
    w[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return w;
  endfunction

endpackage

// File: rtl/link_sched_rr_pick.sv
// Round-robin pick: lowest-numbered requester at or above ptr, wrapping modulo NCH.
module rr_pick
  import link_sched_pkg::*;
#(
  parameter int NCH = 16,
  parameter int PW  = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  grant,
  output logic           any
);

  localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

  logic [PW:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= NCH_W) idx = idx - NCH_W;
      if (req[idx[PW-1:0]]) begin
        grant = idx[PW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_sched.sv
// Link scheduler: packetises channel words onto a single 16-bit link with round-robin
// channel selection, trigger injection between packets and stall-timeout abort.
module link_sched
  import link_sched_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int TOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [16*NCH-1:0] data,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    ack,
  input  logic              trigger,
  output logic [15:0]       dout,
  output logic              kchar
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [PW-1:0] LAST_CH   = PW'(NCH - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TOUT - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  hdr_len_t      cnt_q, cnt_d;
  logic          gap_q, gap_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          pending_q, pending_d;
  logic [15:0]   dout_q, dout_d;
  logic          kchar_q, kchar_d;

  logic [PW-1:0] pick_g;
  logic          pick_any;
  logic [15:0]   word_g;
  logic [PW-1:0] next_ptr;

  rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_g),
    .any   (pick_any)
  );

  assign word_g   = data[16*gnt_q +: 16];
  assign next_ptr = (gnt_q == LAST_CH) ? '0 : gnt_q + 1'b1;

  // ack is decoded straight from state so the word it pops is registered onto dout
  // on the same edge, making dout trail its ack by exactly one cycle.
  always_comb begin
    ack = '0;
    if (state_q == S_HDR || (state_q == S_DATA && req[gnt_q])) ack[gnt_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    stall_d   = stall_q;
    pending_d = pending_q | trigger;
    dout_d    = IDLE_WORD;
    kchar_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          dout_d    = TRIG_WORD;
          pending_d = 1'b0;
        end else if (pick_any) begin
          gnt_d   = pick_g;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        dout_d  = word_g;
        kchar_d = 1'b0;
        cnt_d   = hdr_len(word_g);
        stall_d = '0;
        gap_d   = 1'b0;
        if (hdr_len(word_g) == '0) begin
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end

      // Two quiet cycles give the source time to refresh data/req after its pop.
      S_GAP: begin
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = S_DATA;
        end else begin
          gap_d = 1'b1;
        end
      end

      S_DATA: begin
        if (req[gnt_q]) begin
          dout_d  = word_g;
          kchar_d = 1'b0;
          cnt_d   = cnt_q - 1'b1;
          stall_d = '0;
          gap_d   = 1'b0;
          if (cnt_q > hdr_len_t'(1)) begin
            state_d = S_GAP;
          end else begin
            ptr_d   = next_ptr;
            state_d = S_IDLE;
          end
        end else if (stall_q == STALL_LIM) begin
          dout_d  = ABORT_WORD;
          stall_d = '0;
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      stall_q   <= '0;
      pending_q <= 1'b0;
      dout_q    <= IDLE_WORD;
      kchar_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      stall_q   <= stall_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      kchar_q   <= kchar_d;
    end
  end

  assign dout  = dout_q;
  assign kchar = kchar_q;

endmodule

// File: tb/tb_link_sched.sv
// Bench for link_sched: per-channel packet sources driving a time-stamped packet model.
module tb_link_sched;
  import link_sched_pkg::*;

  localparam int NCH  = 16;
  localparam int TOUT = 24;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b1;
  logic [16*NCH-1:0] data    = '0;
  logic [NCH-1:0]    req     = '0;
  logic [NCH-1:0]    ack;
  logic              trigger = 1'b0;
  logic [15:0]       dout;
  logic              kchar;

  link_sched #(.NCH(NCH), .TOUT(TOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .req     (req),
    .ack     (ack),
    .trigger (trigger),
    .dout    (dout),
    .kchar   (kchar)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Source side: one word queue per channel, words left in the open packet, forced req-low time.
  logic [15:0]    srcq[NCH][$];
  int             rem[NCH];
  int             hold[NCH];
  int             ack_cnt[NCH];
  int             hdr_served[$];
  logic [16:0]    obs[$];
  logic           rnd_en   = 1'b0;
  logic           trig_req = 1'b0;
  logic [NCH-1:0] act_ack;
  int             abort_ch = -1;

  // Reference model: packet-level bookkeeping with cycle time stamps.
  int          m_cyc = 0, m_hdr_at = 0, m_next_at = 0, m_ch = 0, m_left = 0, m_stall = 0, m_ptr = 0;
  bit          m_busy = 0, m_pend = 0;
  logic [15:0] exp_w = IDLE_WORD;
  logic        exp_k = 1'b1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      req[k] = (srcq[k].size() > 0) && (hold[k] == 0);
      data[16*k +: 16] = (srcq[k].size() > 0) ? srcq[k][0] : 16'h0000;
    end
  endtask

  task automatic enq(input int k, input int len);
    srcq[k].push_back({1'b1, 3'($urandom_range(0, 7)), 12'(len)});
    for (int i = 0; i < len; i++) srcq[k].push_back(16'($urandom));
    drive();
  endtask

  function automatic int rr(input logic [NCH-1:0] r, input int p);
    for (int i = 0; i < NCH; i++) if (r[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  function automatic int hs(input int i);
    return (hdr_served.size() > i) ? hdr_served[i] : -1;
  endfunction

  function automatic int count_obs(input logic [16:0] w);
    int n = 0;
    foreach (obs[i]) if (obs[i] == w) n++;
    return n;
  endfunction

  task automatic pkt_done();
    m_busy   = 0;
    m_ptr    = (m_ch + 1) % NCH;
  endtask

  // Predicts the ack for the coming edge and the link word that edge registers.
  task automatic model_step(output logic [NCH-1:0] eack);
    logic [15:0] w;
    logic        k;
    bit          trig_out;
    int          p;
    w = IDLE_WORD; k = 1'b1; eack = '0; trig_out = 0;
    if (!m_busy) begin
      if (m_pend) begin
        w = TRIG_WORD; trig_out = 1; m_pend = 0;
      end else begin
        p = rr(req, m_ptr);
        if (p >= 0) begin m_ch = p; m_busy = 1; m_hdr_at = m_cyc + 1; end
      end
    end else if (m_cyc == m_hdr_at) begin
      eack[m_ch] = 1'b1; w = data[16*m_ch +: 16]; k = 1'b0;
      m_left = int'(w[11:0]); m_stall = 0;
      if (m_left == 0) pkt_done(); else m_next_at = m_cyc + 3;
    end else if (m_cyc >= m_next_at) begin
      if (req[m_ch]) begin
        eack[m_ch] = 1'b1; w = data[16*m_ch +: 16]; k = 1'b0;
        m_left--; m_stall = 0;
        if (m_left == 0) pkt_done(); else m_next_at = m_cyc + 3;
      end else begin
        m_stall++;
        if (m_stall == TOUT) begin w = ABORT_WORD; abort_ch = m_ch; pkt_done(); end
      end
    end
    if (trigger && !trig_out) m_pend = 1;
    exp_w = w; exp_k = k; m_cyc++;
  endtask

  task automatic random_traffic();
    int k;
    if ($urandom_range(0, 39) == 0) trigger = 1'b1;
    if ($urandom_range(0, 4) == 0) begin
      k = $urandom_range(0, NCH - 1);
      if (srcq[k].size() == 0) enq(k, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5));
    end
    if ($urandom_range(0, 11) == 0) begin
      k = $urandom_range(0, NCH - 1);
      if (rem[k] > 0 && hold[k] == 0)
        hold[k] = ($urandom_range(0, 7) == 0) ? TOUT + 2 : $urandom_range(1, 6);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] eack;
    logic [15:0]    w;
    @(negedge clk);
    expect_eq("dout", 32'(dout), 32'(exp_w));
    expect_eq("kchar", 32'(kchar), 32'(exp_k));
    if (!(dout == IDLE_WORD && kchar)) obs.push_back({kchar, dout});
    model_step(eack);
    expect_eq("ack", 32'(ack), 32'(eack));
    act_ack = ack;
    for (int k = 0; k < NCH; k++) if (ack[k]) begin
      ack_cnt[k]++;
      if (rem[k] == 0) hdr_served.push_back(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) if (act_ack[k] && srcq[k].size() > 0) begin
      w = srcq[k].pop_front();
      if (rem[k] == 0) rem[k] = int'(w[11:0]); else rem[k]--;
    end
    if (abort_ch >= 0) begin
      while (rem[abort_ch] > 0 && srcq[abort_ch].size() > 0) begin
        void'(srcq[abort_ch].pop_front());
        rem[abort_ch]--;
      end
      rem[abort_ch] = 0;
      abort_ch = -1;
    end
    for (int k = 0; k < NCH; k++) if (hold[k] > 0) hold[k]--;
    trigger  = trig_req;
    trig_req = 1'b0;
    if (rnd_en) random_traffic();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_release();
    for (int k = 0; k < NCH; k++) begin
      srcq[k].delete(); rem[k] = 0; hold[k] = 0;
    end
    trigger = 1'b0; trig_req = 1'b0; abort_ch = -1;
    m_busy = 0; m_ptr = 0; m_pend = 0; exp_w = IDLE_WORD; exp_k = 1'b1;
    drive();
    rst_n = 1'b1;
  endtask

  task automatic async_reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    expect_eq("rst_async_dout", 32'(dout), 32'(IDLE_WORD));
    expect_eq("rst_async_kchar", 32'(kchar), 32'd1);
    expect_eq("rst_async_ack", 32'(ack), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_release();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_eq("rst_dout", 32'(dout), 32'(IDLE_WORD));
    expect_eq("rst_kchar", 32'(kchar), 32'd1);
    expect_eq("rst_ack", 32'(ack), 32'd0);
    reset_release();

    // Simultaneous requesters from ptr=0, then from ptr=1 so channel 0 wraps to last.
    enq(0, 1); enq(5, 1); enq(15, 1);
    hdr_served.delete();
    run(40);
    expect_eq("order0_first", 32'(hs(0)), 32'd0);
    expect_eq("order0_second", 32'(hs(1)), 32'd5);
    expect_eq("order0_third", 32'(hs(2)), 32'd15);
    enq(0, 0);
    run(10);
    hdr_served.delete();
    enq(0, 1); enq(5, 1); enq(15, 1);
    run(40);
    expect_eq("order1_first", 32'(hs(0)), 32'd5);
    expect_eq("order1_second", 32'(hs(1)), 32'd15);
    expect_eq("order1_last", 32'(hs(2)), 32'd0);

    // Channel 2 packet with three data words.
    ack_cnt[2] = 0; obs.delete();
    enq(2, 3);
    run(25);
    expect_eq("ch2_acks", 32'(ack_cnt[2]), 32'd4);
    expect_eq("ch2_words", 32'(obs.size()), 32'd4);

    // Zero-length packet.
    ack_cnt[7] = 0; obs.delete();
    enq(7, 0);
    run(10);
    expect_eq("l0_acks", 32'(ack_cnt[7]), 32'd1);
    expect_eq("l0_words", 32'(obs.size()), 32'd1);

    // Trigger mid-packet is held until the packet boundary.
    obs.delete();
    enq(3, 3); enq(4, 1);
    for (int i = 0; i < 20 && rem[3] != 3; i++) step();
    trig_req = 1'b1;
    run(30);
    expect_eq("trig_count", 32'(count_obs({1'b1, TRIG_WORD})), 32'd1);
    expect_eq("trig_pos", 32'((obs.size() > 4) ? obs[4] : 17'h0), 32'({1'b1, TRIG_WORD}));
    expect_eq("trig_words", 32'(obs.size()), 32'd7);

    // Stall past the timeout on channel 6, channel 8 must follow.
    obs.delete(); hdr_served.delete();
    enq(6, 3); enq(8, 1);
    for (int i = 0; i < 60 && rem[6] != 2; i++) step();
    expect_eq("stall_setup", 32'(rem[6]), 32'd2);
    hold[6] = TOUT + 5;
    drive();
    run(TOUT + 30);
    expect_eq("abort_count", 32'(count_obs({1'b1, ABORT_WORD})), 32'd1);
    expect_eq("abort_first", 32'(hs(0)), 32'd6);
    expect_eq("abort_next", 32'(hs(1)), 32'd8);

    // Reset mid-packet with ptr away from zero; afterwards ptr must restart at 0.
    enq(9, 0);
    run(10);
    enq(3, 4);
    for (int i = 0; i < 30 && rem[3] != 3; i++) step();
    run(2);
    async_reset_mid();
    hdr_served.delete();
    enq(1, 1); enq(12, 1);
    run(30);
    expect_eq("post_rst_first", 32'(hs(0)), 32'd1);
    expect_eq("post_rst_second", 32'(hs(1)), 32'd12);

    // Randomised traffic, stalls and triggers, with one asynchronous reset midway.
    rnd_en = 1'b1;
    run(2000);
    async_reset_mid();
    run(2000);
    rnd_en = 1'b0;
    run(TOUT * 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
